// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: shared FSM state type, sizing constants and index wrap helper for irq_ctrl.
package irq_ctrl_pkg;
  localparam int MAX_IRQ = 8;
  localparam int VEC_W = 3;
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  function automatic int wrap_idx(input int s, input int k, input int n);
    return (s + k >= n) ? s + k - n : s + k;
  endfunction
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational winner search over eligible lines, starting at index start and wrapping at N.
module irq_prio_enc import irq_ctrl_pkg::*; #(
  parameter int N = MAX_IRQ
) (
  input  logic [MAX_IRQ-1:0] eligible,
  input  logic [VEC_W-1:0]   start,
  output logic               valid,
  output logic [VEC_W-1:0]   idx
);
  logic [VEC_W-1:0] cand;
  // Walk from the far end back toward start so the nearest eligible line is the last write.
  always_comb begin
    valid = 1'b0;
    idx = '0;
    cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = VEC_W'(wrap_idx(int'(start), k, N));
      if (eligible[cand]) begin
        valid = 1'b1;
        idx = cand;
      end
    end
  end
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: non-nesting interrupt controller with edge/level pending, enable mask and IDLE/REQ/SERVICE handshake.
// Define IRQ_CTRL_RR_EN for round-robin arbitration; otherwise lowest index wins.
module irq_ctrl import irq_ctrl_pkg::*; #(
  parameter int NUM_IRQ = 8,
  parameter bit EDGE    = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [MAX_IRQ-1:0] irq_req,
  input  logic               ie_we,
  input  logic [MAX_IRQ-1:0] ie_wdata,
  input  logic               cpu_ack,
  input  logic               cpu_iret,
  output logic               interrupt,
  output logic [VEC_W-1:0]   irq,
  output logic [MAX_IRQ-1:0] pending,
  output logic [MAX_IRQ-1:0] ie,
  output logic               in_service
);
  localparam logic [MAX_IRQ-1:0] MASK = MAX_IRQ'((1 << NUM_IRQ) - 1);
  state_t state_q, state_d;
  logic [VEC_W-1:0] irq_q, irq_d, start, win;
  logic [MAX_IRQ-1:0] pend_q, pend_d, ie_q, ie_d, prev_q, prev_d, set, eligible;
  logic valid, take;
  assign take = (state_q == REQ) && cpu_ack;
`ifdef IRQ_CTRL_RR_EN
  logic [VEC_W-1:0] ptr_q, ptr_d;
  always_comb ptr_d = take ? ((int'(irq_q) + 1 >= NUM_IRQ) ? '0 : irq_q + 1'b1) : ptr_q;
  always_ff @(posedge clock) ptr_q <= reset ? '0 : ptr_d;
  assign start = ptr_q;
`else
  assign start = '0;
`endif
  irq_prio_enc #(.N(NUM_IRQ)) u_enc (.eligible(eligible), .start(start), .valid(valid), .idx(win));
  // A new set event outranks the ack clear on the same bit.
  always_comb begin
    prev_d = irq_req & MASK;
    set = EDGE ? (prev_d & ~prev_q) : prev_d;
    eligible = pend_q & ie_q;
    ie_d = ie_we ? (ie_wdata & MASK) : ie_q;
    pend_d = (pend_q & ~(take ? (MAX_IRQ'(1) << irq_q) : '0)) | set;
    state_d = state_q;
    irq_d = irq_q;
    case (state_q)
      IDLE: if (valid) begin
        state_d = REQ;
        irq_d = win;
      end
      REQ: state_d = cpu_ack ? SERVICE : (eligible[irq_q] ? REQ : IDLE);
      SERVICE: state_d = cpu_iret ? IDLE : SERVICE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      irq_q <= '0;
      pend_q <= '0;
      ie_q <= '0;
      prev_q <= '0;
    end else begin
      state_q <= state_d;
      irq_q <= irq_d;
      pend_q <= pend_d;
      ie_q <= ie_d;
      prev_q <= prev_d;
    end
  end
  assign interrupt = (state_q == REQ);
  assign in_service = (state_q == SERVICE);
  assign irq = irq_q;
  assign pending = pend_q;
  assign ie = ie_q;
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scoreboard bench for irq_ctrl; expectations adapt to IRQ_CTRL_RR_EN.
module tb_irq_ctrl;
`ifdef IRQ_CTRL_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clock = 1'b0, reset, ie_we, cpu_ack, cpu_iret, interrupt, in_service;
  logic [7:0] irq_req, ie_wdata, pending, ie;
  logic [2:0] irq;
  int vectors = 0, miscompares = 0;
  string tq[$];
  logic [7:0] vq[$];
  logic [7:0] first, second, e;

  irq_ctrl dut (.clock(clock), .reset(reset), .irq_req(irq_req), .ie_we(ie_we), .ie_wdata(ie_wdata),
                .cpu_ack(cpu_ack), .cpu_iret(cpu_iret), .interrupt(interrupt), .irq(irq),
                .pending(pending), .ie(ie), .in_service(in_service));

  always #5 clock = ~clock;

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic ex(input string t, input logic [7:0] v);
    tq.push_back(t);
    vq.push_back(v);
  endtask

  task automatic chk(input logic [7:0] obs);
    string t;
    logic [7:0] exv;
    vectors++;
    if (vq.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
      return;
    end
    t = tq.pop_front();
    exv = vq.pop_front();
    assert (obs === exv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", t, obs, exv);
    end
  endtask

  initial begin
    reset = 1'b1; irq_req = '0; ie_we = 1'b0; ie_wdata = '0; cpu_ack = 1'b0; cpu_iret = 1'b0;
    ex("rst_int", 8'h00); ex("rst_irq", 8'h00); ex("rst_pend", 8'h00); ex("rst_ie", 8'h00); ex("rst_svc", 8'h00);
    cyc(2);
    reset = 1'b0;
    chk({7'b0, interrupt}); chk({5'b0, irq}); chk(pending); chk(ie); chk({7'b0, in_service});
    // single edge on line 5
    ie_we = 1'b1; ie_wdata = 8'hFF; ex("ie_load", 8'hFF);
    cyc(); ie_we = 1'b0;
    chk(ie);
    irq_req = 8'h20; ex("edge5_pend", 8'h20); ex("edge5_int0", 8'h00);
    cyc(); irq_req = 8'h00;
    chk(pending); chk({7'b0, interrupt});
    ex("edge5_int", 8'h01); ex("edge5_irq", 8'h05);
    cyc();
    chk({7'b0, interrupt}); chk({5'b0, irq});
    cpu_ack = 1'b1; ex("ack5_pend", 8'h00); ex("ack5_svc", 8'h01); ex("ack5_int", 8'h00); ex("ack5_irqhold", 8'h05);
    cyc(); cpu_ack = 1'b0;
    chk(pending); chk({7'b0, in_service}); chk({7'b0, interrupt}); chk({5'b0, irq});
    cpu_iret = 1'b1; ex("iret5_svc", 8'h00);
    cyc(); cpu_iret = 1'b0;
    chk({7'b0, in_service});
    // lines 6 and 2 together
    first = RR ? 8'd6 : 8'd2;
    second = RR ? 8'd2 : 8'd6;
    irq_req = 8'h44;
    cyc(); irq_req = 8'h00;
    ex("pair_first", first);
    cyc();
    chk({5'b0, irq});
    cpu_ack = 1'b1; ex("pair_pend", 8'h44 & ~(8'h01 << first));
    cyc(); cpu_ack = 1'b0;
    chk(pending);
    cpu_iret = 1'b1;
    cyc(); cpu_iret = 1'b0;
    ex("pair_second", second); ex("pair_second_int", 8'h01);
    cyc();
    chk({5'b0, irq}); chk({7'b0, interrupt});
    cpu_ack = 1'b1;
    cyc(); cpu_ack = 1'b0; cpu_iret = 1'b1; ex("pair_done", 8'h00);
    cyc(); cpu_iret = 1'b0;
    chk(pending);
    // enable withdrawn while in REQ for line 4
    irq_req = 8'h10;
    cyc(); irq_req = 8'h00;
    ex("l4_irq", 8'h04);
    cyc();
    chk({5'b0, irq});
    ie_we = 1'b1; ie_wdata = 8'h00; ex("l4_ie0", 8'h00); ex("l4_int_hold", 8'h01);
    cyc(); ie_we = 1'b0;
    chk(ie); chk({7'b0, interrupt});
    ex("l4_drop", 8'h00); ex("l4_idle", 8'h00); ex("l4_pend", 8'h10);
    cyc();
    chk({7'b0, interrupt}); chk({7'b0, in_service}); chk(pending);
    ie_we = 1'b1; ie_wdata = 8'hFF;
    cyc(); ie_we = 1'b0;
    ex("l4_regrant", 8'h04);
    cyc();
    chk({5'b0, irq});
    cpu_ack = 1'b1;
    cyc(); cpu_ack = 1'b0; cpu_iret = 1'b1;
    cyc(); cpu_iret = 1'b0;
    // edge on line 0 coincides with its ack
    irq_req = 8'h01;
    cyc(); irq_req = 8'h00;
    ex("l0_irq", 8'h00); ex("l0_int", 8'h01);
    cyc();
    chk({5'b0, irq}); chk({7'b0, interrupt});
    irq_req = 8'h01; cpu_ack = 1'b1; ex("l0_keep", 8'h01); ex("l0_svc", 8'h01);
    cyc(); irq_req = 8'h00; cpu_ack = 1'b0;
    chk(pending); chk({7'b0, in_service});
    cpu_iret = 1'b1;
    cyc(); cpu_iret = 1'b0;
    ex("l0_again_int", 8'h01); ex("l0_again_irq", 8'h00);
    cyc();
    chk({7'b0, interrupt}); chk({5'b0, irq});
    cpu_ack = 1'b1;
    cyc(); cpu_ack = 1'b0; cpu_iret = 1'b1;
    cyc(); cpu_iret = 1'b0;
    // lines 1 and 3 re-pended on every ack
    irq_req = 8'h0A;
    cyc(); irq_req = 8'h00;
    for (int g = 0; g < 4; g++) begin
      e = (RR && g[0]) ? 8'd3 : 8'd1;
      ex("alt_irq", e); ex("alt_int", 8'h01);
      cyc();
      chk({5'b0, irq}); chk({7'b0, interrupt});
      irq_req = 8'h01 << e; cpu_ack = 1'b1; ex("alt_pend", 8'h0A); ex("alt_svc", 8'h01);
      cyc(); irq_req = 8'h00; cpu_ack = 1'b0;
      chk(pending); chk({7'b0, in_service});
      if (g < 3) begin
        cpu_iret = 1'b1;
        cyc(); cpu_iret = 1'b0;
      end
    end
    // reset during SERVICE with pending 0x0A
    reset = 1'b1; ie_we = 1'b1; ie_wdata = 8'hFF; cpu_ack = 1'b1; cpu_iret = 1'b1;
    ex("rst2_int", 8'h00); ex("rst2_irq", 8'h00); ex("rst2_pend", 8'h00); ex("rst2_ie", 8'h00); ex("rst2_svc", 8'h00);
    cyc();
    reset = 1'b0; ie_we = 1'b0; cpu_ack = 1'b0; cpu_iret = 1'b0;
    chk({7'b0, interrupt}); chk({5'b0, irq}); chk(pending); chk(ie); chk({7'b0, in_service});
    cpu_iret = 1'b1; ex("iret_idle_svc", 8'h00); ex("iret_idle_int", 8'h00);
    cyc(); cpu_iret = 1'b0;
    chk({7'b0, in_service}); chk({7'b0, interrupt});
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
